// File: rtl/uart_mem_sender_if.sv
// Host/memory-side bundle for uart_mem_sender: start/abort control, memory read port, serial line and status.
// master is the sender; slave is the host and memory that drive it.
interface uart_mem_sender_if #(
  parameter int width = 12
);
  logic             start;
  logic             abort;
  logic [7:0]       baud_div;
  logic [width-1:0] mem_addr;
  logic             mem_rd;
  logic [7:0]       mem_data;
  logic             uart_tx;
  logic             busy;
  logic             done;
  logic [7:0]       checksum;

  modport master (
    input  start, abort, baud_div, mem_data,
    output mem_addr, mem_rd, uart_tx, busy, done, checksum
  );

  modport slave (
    output start, abort, baud_div, mem_data,
    input  mem_addr, mem_rd, uart_tx, busy, done, checksum
  );
endinterface

// File: rtl/uart_mem_sender.sv
// Streams preamble, the 2^width-byte memory image and an 8-bit checksum as back-to-back 8N1 frames.
// Latency: first start bit on the accept edge, done 10*P*(2^width+2)+1 cycles later; no backpressure, abort ends at a frame boundary.
module uart_mem_sender #(
  parameter int         width    = 12,
  parameter logic [7:0] PREAMBLE = 8'hA5
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_mem_sender_if.master   io_if
);
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_CSUM, S_DONE} state_t;

  localparam logic [width-1:0] LAST_ADDR = '1;

  state_t           r_state;
  logic [7:0]       r_period;
  logic [7:0]       r_div;
  logic [3:0]       r_bit;
  logic [7:0]       r_shift;
  logic [7:0]       r_next;
  logic [7:0]       r_csum;
  logic [width-1:0] r_addr;
  logic [width-1:0] r_idx;
  logic             r_tx;
  logic             r_busy;
  logic             r_done;
  logic             r_rd;
  logic             r_rd_q;
  logic             r_abort;

  logic             w_bit_end;
  logic             w_abort;
  logic             w_want_rd;
  logic [7:0]       w_fetch_byte;

  assign w_bit_end    = (r_div == r_period - 8'd1);
  assign w_abort      = io_if.abort || r_abort;
  assign w_want_rd    = (r_state == S_PRE) || ((r_state == S_DATA) && (r_idx != LAST_ADDR));
  // With a 2-cycle bit the read data arrives on the very cycle the next frame loads.
  assign w_fetch_byte = r_rd_q ? io_if.mem_data : r_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_period <= 8'd2;
      r_div    <= 8'd0;
      r_bit    <= 4'd0;
      r_shift  <= 8'd0;
      r_next   <= 8'd0;
      r_csum   <= 8'd0;
      r_addr   <= '0;
      r_idx    <= '0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rd     <= 1'b0;
      r_rd_q   <= 1'b0;
      r_abort  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_rd   <= 1'b0;
      r_rd_q <= r_rd;
      if (r_rd_q) r_next <= io_if.mem_data;
      if (r_rd && (r_addr != LAST_ADDR)) r_addr <= r_addr + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (io_if.start && !io_if.abort) begin
            r_state  <= S_PRE;
            r_busy   <= 1'b1;
            r_csum   <= 8'd0;
            r_addr   <= '0;
            r_tx     <= 1'b0;
            r_shift  <= PREAMBLE;
            r_div    <= 8'd0;
            r_bit    <= 4'd0;
            r_abort  <= 1'b0;
            r_period <= (io_if.baud_div < 8'd2) ? 8'd2 : io_if.baud_div;
          end
        end

        S_PRE, S_DATA, S_CSUM: begin
          if (io_if.abort) r_abort <= 1'b1;
          if (!w_bit_end) begin
            r_div <= r_div + 8'd1;
          end else begin
            r_div <= 8'd0;
            if (r_bit != 4'd9) begin
              r_bit <= r_bit + 4'd1;
              r_tx  <= (r_bit == 4'd8) ? 1'b1 : r_shift[r_bit[2:0]];
              if ((r_bit == 4'd8) && w_want_rd && !w_abort) r_rd <= 1'b1;
            end else begin
              r_bit <= 4'd0;
              if (w_abort) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_abort <= 1'b0;
              end else if (r_state == S_CSUM) begin
                r_state <= S_DONE;
              end else begin
                r_tx <= 1'b0;
                if ((r_state == S_DATA) && (r_idx == LAST_ADDR)) begin
                  r_state <= S_CSUM;
                  r_shift <= r_csum;
                end else begin
                  r_state <= S_DATA;
                  r_shift <= w_fetch_byte;
                  r_csum  <= r_csum + w_fetch_byte;
                  r_idx   <= (r_state == S_PRE) ? '0 : r_idx + 1'b1;
                end
              end
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_if.uart_tx  = r_tx;
  assign io_if.busy     = r_busy;
  assign io_if.done     = r_done;
  assign io_if.mem_rd   = r_rd;
  assign io_if.mem_addr = r_addr;
  assign io_if.checksum = r_csum;
endmodule

// File: tb/tb_uart_mem_sender.sv
// Randomised scoreboard bench for uart_mem_sender: a line decoder, a read-strobe monitor and a done monitor
// pop expectations pushed by the stimulus from a frame-level model of the transfer.
module tb_uart_mem_sender;
  localparam int W = 2;
  localparam int M = 1 << W;
  localparam int N = M + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_mem_sender_if #(.width(W)) bus();

  uart_mem_sender #(.width(W), .PREAMBLE(8'hA5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_if (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [M];
  always @(posedge clk) if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t byte_q[$];
  exp_t rd_q[$];
  int   done_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  bit quiet   = 1'b0;
  int cur_p   = 2;

  function automatic void check(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void unexpected(string nm, int act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got 0x%0h, expected nothing (cycle %0d)", nm, act, cyc);
  endfunction

  // Serial line decoder: samples each bit at its middle using the period the stimulus announced.
  initial begin
    int p;
    int s;
    logic [9:0] fr;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.uart_tx == 1'b0)) begin
        p = cur_p;
        s = cyc;
        repeat (p / 2) @(negedge clk);
        fr[0] = bus.uart_tx;
        for (int i = 1; i < 10; i++) begin
          repeat (p) @(negedge clk);
          fr[i] = bus.uart_tx;
        end
        if (!quiet) begin
          if (byte_q.size() == 0) unexpected("unexpected_byte", int'(fr[8:1]));
          else begin
            e = byte_q.pop_front();
            check("byte", int'(fr[8:1]), e.val);
            check("frame_start_cycle", s, e.cyc);
            check("framing_stop_start", int'({fr[9], fr[0]}), 2);
          end
        end
      end
    end
  end

  // Read-strobe and done monitor.
  initial begin
    exp_t e;
    int d;
    forever begin
      @(negedge clk);
      if (rst_n && !quiet) begin
        if (bus.mem_rd) begin
          if (rd_q.size() == 0) unexpected("unexpected_mem_rd", int'(bus.mem_addr));
          else begin
            e = rd_q.pop_front();
            check("mem_rd_addr", int'(bus.mem_addr), e.val);
            check("mem_rd_cycle", cyc, e.cyc);
          end
        end
        if (bus.done) begin
          if (done_q.size() == 0) unexpected("unexpected_done", cyc);
          else begin
            d = done_q.pop_front();
            check("done_cycle", cyc, d);
          end
        end
      end
    end
  end

  task automatic run_xfer(input int bd, input bit restart, input int abort_off);
    int p, t0, ta, kmax, sum, lim, exp_end;
    int f[N];
    p = (bd < 2) ? 2 : bd;
    cur_p = p;
    sum = 0;
    for (int i = 0; i < M; i++) sum += int'(mem[i]);
    f[0] = 'hA5;
    for (int i = 0; i < M; i++) f[i + 1] = int'(mem[i]);
    f[N - 1] = sum % 256;

    @(negedge clk);
    bus.baud_div = bd[7:0];
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    t0 = cyc;
    ta = t0 + abort_off;

    kmax = (abort_off < 0) ? N - 1 : abort_off / (10 * p);
    for (int k = 0; k <= kmax; k++) byte_q.push_back('{f[k], t0 + 10 * p * k});
    for (int j = 0; j < M; j++) begin
      int c;
      c = t0 + 10 * p * j + 9 * p;
      if ((abort_off < 0) || (c - 1 < ta)) rd_q.push_back('{j, c});
    end
    if (abort_off < 0) done_q.push_back(t0 + 10 * p * N + 1);
    exp_end = (abort_off < 0) ? t0 + 10 * p * N + 1 : t0 + 10 * p * (kmax + 1);

    bus.baud_div = 8'($urandom_range(0, 255));
    if (restart) begin
      while (cyc < t0 + 23 * p) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    if (abort_off >= 0) begin
      while (cyc < ta) @(negedge clk);
      bus.abort = 1'b1;
    end

    lim = 10 * p * N + 50;
    while (bus.busy && (lim > 0)) begin
      @(negedge clk);
      lim--;
    end
    if (lim == 0) unexpected("busy_timeout", cyc);
    check("busy_fall_cycle", cyc, exp_end);
    bus.abort = 1'b0;

    repeat (3) @(negedge clk);
    check("idle_line", int'(bus.uart_tx), 1);
    check("bytes_left", byte_q.size(), 0);
    check("reads_left", rd_q.size(), 0);
    check("done_left", done_q.size(), 0);
    if (abort_off < 0) begin
      check("checksum", int'(bus.checksum), sum % 256);
      check("mem_addr_hold", int'(bus.mem_addr), M - 1);
    end
    byte_q.delete();
    rd_q.delete();
    done_q.delete();
  endtask

  initial begin
    int bd, mode, p;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.baud_div = 8'd4;

    repeat (3) @(negedge clk);
    check("rst_uart_tx", int'(bus.uart_tx), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_mem_rd", int'(bus.mem_rd), 0);
    check("rst_mem_addr", int'(bus.mem_addr), 0);
    check("rst_checksum", int'(bus.checksum), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h80; mem[3] = 8'hFF;
    run_xfer(4, 1'b0, -1);
    check("plan_checksum", int'(bus.checksum), 'h82);
    run_xfer(4, 1'b1, -1);
    run_xfer(0, 1'b0, -1);
    run_xfer(1, 1'b0, -1);
    run_xfer(4, 1'b0, 20 * 4 + 3 * 4 + 2);

    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    check("start_with_abort_busy", int'(bus.busy), 0);
    check("start_with_abort_tx", int'(bus.uart_tx), 1);

    quiet = 1'b1;
    cur_p = 3;
    @(negedge clk);
    bus.baud_div = 8'd3;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (47) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tx", int'(bus.uart_tx), 1);
    check("async_rst_busy", int'(bus.busy), 0);
    check("async_rst_mem_rd", int'(bus.mem_rd), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    quiet = 1'b0;
    check("post_rst_addr", int'(bus.mem_addr), 0);
    run_xfer(3, 1'b0, -1);

    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < M; i++) mem[i] = 8'($urandom_range(0, 255));
      bd   = $urandom_range(0, 9);
      mode = $urandom_range(0, 3);
      p    = (bd < 2) ? 2 : bd;
      if (mode == 0) run_xfer(bd, 1'b0, $urandom_range(0, 10 * p * N - 1));
      else if (mode == 1) run_xfer(bd, 1'b1, -1);
      else run_xfer(bd, 1'b0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end
endmodule
